wb_trace_capture: RTL and testbench

WB_TRACE_CAPTURE -- requirements
Module: wb_trace_capture

---
 rtl/wb_trace_capture.sv | 147 ++++++++++++++
 tb/tb_wb_trace_capture.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_capture.sv
`default_nettype none
// ============================================================================
// Module      : wb_trace_capture
// Description : Captures processor writeback events (register, data and
//               forwarding selects) with a cycle stamp into a trace FIFO.
//               Overflowing events are dropped and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_trace_capture #(
   parameter int DEPTH      = 16,
   parameter int STAMP_W    = 16,
   parameter int FILTER_XZR = 1
) (
   input  logic                      clk,
   input  logic                      Reset,
   input  logic                      cap_en,
   input  logic                      clr,
   input  logic                      wb_valid,
   input  logic [4:0]                wb_rd,
   input  logic [63:0]               wb_data,
   input  logic [1:0]                fwd_a,
   input  logic [1:0]                fwd_b,
   input  logic                      rd_req,
   output logic                      rd_valid,
   output logic [STAMP_W+72:0]       rd_entry,
   output logic                      empty,
   output logic                      full,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      overflow,
   output logic [7:0]                drop_cnt
);

   localparam int                 c_aw       = $clog2(DEPTH);
   localparam int                 c_ew       = STAMP_W + 73;
   localparam logic [c_aw:0]      c_cnt_one  = {{c_aw{1'b0}}, 1'b1};
   localparam logic [c_aw:0]      c_cnt_full = (c_aw+1)'(DEPTH);
   localparam logic [c_aw-1:0]    c_ptr_one  = {{(c_aw-1){1'b0}}, 1'b1};
   localparam logic [STAMP_W-1:0] c_stp_one  = {{(STAMP_W-1){1'b0}}, 1'b1};

   logic [c_ew-1:0]    r_mem [DEPTH];
   logic [c_aw-1:0]    r_wr_ptr;
   logic [c_aw-1:0]    r_rd_ptr;
   logic [c_aw:0]      r_count;
   logic               r_empty;
   logic               r_full;
   logic               r_overflow;
   logic [7:0]         r_drop_cnt;
   logic [STAMP_W-1:0] r_stamp;
   logic               r_rd_valid;
   logic [c_ew-1:0]    r_rd_entry;

   logic               w_cap;
   logic               w_rd_acc;
   logic               w_wr_acc;
   logic               w_drop;
   logic [c_aw:0]      w_count_nxt;

   // Qualify capture events and decide what the FIFO does this cycle; clr overrides both sides
   always_comb begin
      w_cap    = cap_en && wb_valid && !((FILTER_XZR != 0) && (wb_rd == 5'd31));
      w_rd_acc = rd_req && !r_empty && !clr;
      // a simultaneous read frees the slot, so a full FIFO can still accept
      w_wr_acc = w_cap && (!r_full || w_rd_acc) && !clr;
      w_drop   = w_cap && r_full && !w_rd_acc && !clr;
      w_count_nxt = r_count;
      if (w_wr_acc && !w_rd_acc)
         w_count_nxt = r_count + c_cnt_one;
      else if (!w_wr_acc && w_rd_acc)
         w_count_nxt = r_count - c_cnt_one;
   end

   // Trace storage: entries need no reset because pointers define validity
   always_ff @(posedge clk) begin
      if (w_wr_acc)
         r_mem[r_wr_ptr] <= {r_stamp, fwd_b, fwd_a, wb_rd, wb_data};
   end

   // Free-running cycle stamp, only reset touches it
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset)
         r_stamp <= '0;
      else
         r_stamp <= r_stamp + c_stp_one;
   end

   // Pointers, occupancy and the registered empty/full flags
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
      end else if (clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
      end else begin
         if (w_wr_acc)
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         if (w_rd_acc)
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         r_count <= w_count_nxt;
         r_empty <= (w_count_nxt == '0);
         r_full  <= (w_count_nxt == c_cnt_full);
      end
   end

   // Sticky overflow flag and saturating drop counter
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else if (clr) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (r_drop_cnt != 8'hFF)
            r_drop_cnt <= r_drop_cnt + 8'd1;
      end
   end

   // Read port: one-cycle latency, entry holds its last value when idle
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_rd_valid <= 1'b0;
         r_rd_entry <= '0;
      end else begin
         r_rd_valid <= w_rd_acc;
         if (w_rd_acc)
            r_rd_entry <= r_mem[r_rd_ptr];
      end
   end

   assign rd_valid = r_rd_valid;
   assign rd_entry = r_rd_entry;
   assign empty    = r_empty;
   assign full     = r_full;
   assign count    = r_count;
   assign overflow = r_overflow;
   assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_trace_capture
// Description : Self-checking bench for wb_trace_capture (vector table plus
//               directed sequences, entries checked through a scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_trace_capture;

   localparam int DEPTH = 16;

   logic         clk;
   logic         Reset;
   logic         cap_en;
   logic         clr;
   logic         wb_valid;
   logic [4:0]   wb_rd;
   logic [63:0]  wb_data;
   logic [1:0]   fwd_a;
   logic [1:0]   fwd_b;
   logic         rd_req;
   logic         rd_valid;
   logic [88:0]  rd_entry;
   logic         empty;
   logic         full;
   logic [4:0]   count;
   logic         overflow;
   logic [7:0]   drop_cnt;

   wb_trace_capture #(.DEPTH(DEPTH), .STAMP_W(16), .FILTER_XZR(1)) dut (
      .clk      (clk),
      .Reset    (Reset),
      .cap_en   (cap_en),
      .clr      (clr),
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .fwd_a    (fwd_a),
      .fwd_b    (fwd_b),
      .rd_req   (rd_req),
      .rd_valid (rd_valid),
      .rd_entry (rd_entry),
      .empty    (empty),
      .full     (full),
      .count    (count),
      .overflow (overflow),
      .drop_cnt (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   logic [88:0] m_fifo[$];
   logic [88:0] exp_q[$];
   logic [15:0] m_stamp;
   logic        m_rdv;
   logic        m_ovf;
   logic [7:0]  m_drop;
   logic [88:0] m_last;

   typedef struct {
      logic        ce;
      logic        wv;
      logic [4:0]  rd;
      logic [63:0] d;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic        rq;
      logic        cl;
      logic [4:0]  exp_count;
      logic        exp_rdv;
      logic        chk_ent;
      logic [88:0] exp_ent;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_fifo.delete();
      exp_q.delete();
      m_stamp = '0;
      m_rdv   = 1'b0;
      m_ovf   = 1'b0;
      m_drop  = '0;
      m_last  = '0;
   endtask

   // Compare every DUT output against the model; popped scoreboard entries checked here
   task automatic check_all();
      logic [88:0] e;
      chk("rd_valid", rd_valid, m_rdv);
      if (m_rdv) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: got empty queue expected an entry");
         end else begin
            e = exp_q.pop_front();
            chk("rd_entry", rd_entry, e);
            m_last = e;
         end
      end else begin
         chk("rd_entry_hold", rd_entry, m_last);
      end
      chk("count", count, m_fifo.size());
      chk("empty", empty, m_fifo.size() == 0);
      chk("full", full, m_fifo.size() == DEPTH);
      chk("overflow", overflow, m_ovf);
      chk("drop_cnt", drop_cnt, m_drop);
   endtask

   // Drive one cycle of stimulus at a falling edge, update model, check at next falling edge
   task automatic step(input logic ce, input logic wv, input logic [4:0] rd, input logic [63:0] d,
                       input logic [1:0] fa, input logic [1:0] fb, input logic rq, input logic cl);
      logic cap;
      logic racc;
      cap_en = ce; wb_valid = wv; wb_rd = rd; wb_data = d;
      fwd_a = fa; fwd_b = fb; rd_req = rq; clr = cl;
      cap  = ce && wv && (rd != 5'd31);
      racc = rq && (m_fifo.size() != 0);
      if (cl) begin
         m_fifo.delete();
         m_ovf  = 1'b0;
         m_drop = '0;
         m_rdv  = 1'b0;
      end else begin
         m_rdv = racc;
         if (racc)
            exp_q.push_back(m_fifo.pop_front());
         if (cap) begin
            if (m_fifo.size() < DEPTH) begin
               m_fifo.push_back({m_stamp, fb, fa, rd, d});
            end else begin
               m_ovf = 1'b1;
               if (m_drop != 8'hFF)
                  m_drop = m_drop + 8'd1;
            end
         end
      end
      m_stamp = m_stamp + 16'd1;
      @(negedge clk);
      check_all();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{1'b0, 1'b0, 5'd0,  64'h0,    2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 89'h0};
      vecs[1] = '{1'b0, 1'b0, 5'd0,  64'h0,    2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 89'h0};
      vecs[2] = '{1'b0, 1'b0, 5'd0,  64'h0,    2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 89'h0};
      vecs[3] = '{1'b1, 1'b1, 5'd1,  64'hAA,   2'd0, 2'd0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 89'h0};
      vecs[4] = '{1'b0, 1'b0, 5'd0,  64'h0,    2'd0, 2'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1,
                  {16'd3, 2'b00, 2'b00, 5'd1, 64'hAA}};
      vecs[5] = '{1'b1, 1'b1, 5'd31, 64'h55,   2'd1, 2'd1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 89'h0};
      vecs[6] = '{1'b0, 1'b1, 5'd2,  64'h66,   2'd1, 2'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 89'h0};
      vecs[7] = '{1'b1, 1'b1, 5'd5,  64'hBEEF, 2'd2, 2'd1, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 89'h0};
      vecs[8] = '{1'b0, 1'b0, 5'd0,  64'h0,    2'd0, 2'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1,
                  {16'd7, 2'b01, 2'b10, 5'd5, 64'hBEEF}};
      vecs[9] = '{1'b0, 1'b0, 5'd0,  64'h0,    2'd0, 2'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 89'h0};

      Reset = 1'b1; cap_en = 0; clr = 0; wb_valid = 0; wb_rd = 0; wb_data = 0;
      fwd_a = 0; fwd_b = 0; rd_req = 0;
      model_reset();
      #12;
      chk("rst_empty", empty, 1'b1);
      chk("rst_full", full, 1'b0);
      chk("rst_count", count, 5'd0);
      chk("rst_rd_valid", rd_valid, 1'b0);
      chk("rst_rd_entry", rd_entry, 89'h0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_drop_cnt", drop_cnt, 8'd0);
      @(negedge clk);
      Reset = 1'b0;
      model_reset();

      // table-driven basic behaviour
      for (int i = 0; i < 10; i++) begin
         step(vecs[i].ce, vecs[i].wv, vecs[i].rd, vecs[i].d, vecs[i].fa, vecs[i].fb,
              vecs[i].rq, vecs[i].cl);
         chk($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
         chk($sformatf("vec%0d_rd_valid", i), rd_valid, vecs[i].exp_rdv);
         if (vecs[i].chk_ent)
            chk($sformatf("vec%0d_entry", i), rd_entry, vecs[i].exp_ent);
      end

      // fill past full: two drops
      for (int i = 0; i < 18; i++)
         step(1'b1, 1'b1, 5'(i % 30), 64'(i + 1), 2'(i), 2'(i >> 2), 1'b0, 1'b0);
      chk("fill_full", full, 1'b1);
      chk("fill_count", count, 5'd16);
      chk("fill_overflow", overflow, 1'b1);
      chk("fill_drop_cnt", drop_cnt, 8'd2);

      // capture and read together while full
      step(1'b1, 1'b1, 5'd9, 64'hF00D, 2'd3, 2'd3, 1'b1, 1'b0);
      chk("fullrw_count", count, 5'd16);
      chk("fullrw_overflow", overflow, 1'b1);
      chk("fullrw_drop_cnt", drop_cnt, 8'd2);
      chk("fullrw_oldest", rd_entry[63:0], 64'd1);

      // drain: remaining 16 entries in order, newest last
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b0, 5'd0, 64'h0, 2'd0, 2'd0, 1'b1, 1'b0);
         if (i < 15)
            chk($sformatf("drain%0d_data", i), rd_entry[63:0], 64'(i + 2));
      end
      chk("drain_last", rd_entry[63:0], 64'hF00D);
      chk("drain_empty", empty, 1'b1);

      // saturating drop counter then clr (with a simultaneous read request)
      for (int i = 0; i < 316; i++)
         step(1'b1, 1'b1, 5'd4, 64'(i), 2'd1, 2'd0, 1'b0, 1'b0);
      chk("sat_drop_cnt", drop_cnt, 8'd255);
      chk("sat_overflow", overflow, 1'b1);
      step(1'b1, 1'b1, 5'd4, 64'h77, 2'd0, 2'd0, 1'b1, 1'b1);
      chk("clr_count", count, 5'd0);
      chk("clr_overflow", overflow, 1'b0);
      chk("clr_drop_cnt", drop_cnt, 8'd0);
      chk("clr_rd_valid", rd_valid, 1'b0);

      // mid-stream asynchronous reset with five stored entries
      for (int i = 0; i < 5; i++)
         step(1'b1, 1'b1, 5'd6, 64'(100 + i), 2'd2, 2'd2, 1'b0, 1'b0);
      chk("pre_rst_count", count, 5'd5);
      cap_en = 0; wb_valid = 0; rd_req = 0;
      #2 Reset = 1'b1;
      #1;
      chk("arst_empty", empty, 1'b1);
      chk("arst_count", count, 5'd0);
      chk("arst_rd_entry", rd_entry, 89'h0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      Reset = 1'b0;
      step(1'b1, 1'b1, 5'd7, 64'h1234, 2'd1, 2'd2, 1'b0, 1'b0);
      step(1'b0, 1'b0, 5'd0, 64'h0, 2'd0, 2'd0, 1'b1, 1'b0);
      chk("post_rst_stamp", rd_entry[88:73], 16'd0);
      chk("post_rst_data", rd_entry[63:0], 64'h1234);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
